// File: rtl/fu_jump_pipe_pkg.sv
// rtl/fu_jump_pipe_pkg.sv - shared encodings and parameter checks for the jump functional unit
package fu_jump_pkg;

    localparam logic [2:0] CMP_NONE = 3'd0;
    localparam logic [2:0] EQ       = 3'd1;
    localparam logic [2:0] NE       = 3'd2;
    localparam logic [2:0] LT       = 3'd3;
    localparam logic [2:0] LTU      = 3'd4;
    localparam logic [2:0] GE       = 3'd5;
    localparam logic [2:0] GEU      = 3'd6;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/fu_jump_pipe_if.sv
// rtl/fu_jump_pipe_if.sv - issue/result bundle between issue stage and jump functional unit
interface fu_jump_pipe_if #(
    parameter int XLEN = 32
);
    logic            EN;
    logic            flush;
    logic            is_jal;
    logic            JALR;
    logic [2:0]      cmp_ctrl;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] PC;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            done;
    logic [XLEN-1:0] PC_jump;
    logic [XLEN-1:0] PC_wb;
    logic            cmp_res;
    logic            taken;
    logic            mispredict;

    modport master (
        output EN, flush, is_jal, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
               pred_taken, pred_target,
        input  done, PC_jump, PC_wb, cmp_res, taken, mispredict
    );

    modport slave (
        input  EN, flush, is_jal, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
               pred_taken, pred_target,
        output done, PC_jump, PC_wb, cmp_res, taken, mispredict
    );

endinterface

// File: rtl/fu_jump_pipe_cmp.sv
// rtl/fu_jump_pipe_cmp.sv - combinational branch condition comparator
module fu_jump_cmp
    import fu_jump_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic            c
);

    always_comb begin
        c = 1'b0;
        case (ctrl)
            EQ:      c = (a == b);
            NE:      c = (a != b);
            LT:      c = ($signed(a) <  $signed(b));
            LTU:     c = (a <  b);
            GE:      c = ($signed(a) >= $signed(b));
            GEU:     c = (a >= b);
            default: c = 1'b0;
        endcase
    end

endmodule

// File: rtl/fu_jump_pipe.sv
// rtl/fu_jump_pipe.sv - pipelined branch/JAL/JALR resolution unit, LATENCY cycles issue to done
module fu_jump_pipe
    import fu_jump_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int ILEN_B  = 4
) (
    input  logic          clk,
    input  logic          rst,
    fu_jump_pipe_if.slave ifc
);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("fu_jump_pipe: LATENCY out of range");
    end

    typedef struct packed {
        logic            jal;
        logic            jalr;
        logic [2:0]      ctrl;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc_jump;
        logic [XLEN-1:0] pc_wb;
        logic            cmp_res;
        logic            taken;
        logic            mis;
    } res_t;

    op_t               op_q;
    logic              seen_q;
    logic [LATENCY-1:0] valid_q;
    logic              cmp_raw;
    logic              jump;
    logic [XLEN-1:0]   base_sum;
    res_t              res_c;
    res_t              r_out;

    // Operand register only loads on an accepted issue so results hold between ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            seen_q <= 1'b0;
        end else if (ifc.EN && !ifc.flush) begin
            op_q <= '{jal:         ifc.is_jal,
                      jalr:        ifc.JALR,
                      ctrl:        ifc.cmp_ctrl,
                      rs1:         ifc.rs1_data,
                      rs2:         ifc.rs2_data,
                      imm:         ifc.imm,
                      pc:          ifc.PC,
                      pred_taken:  ifc.pred_taken,
                      pred_target: ifc.pred_target};
            seen_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (ifc.flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= ifc.EN;
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    fu_jump_cmp #(.XLEN(XLEN)) u_cmp (
        .a    (op_q.rs1),
        .b    (op_q.rs2),
        .ctrl (op_q.ctrl),
        .c    (cmp_raw)
    );

    assign jump     = op_q.jal | op_q.jalr;
    assign base_sum = op_q.rs1 + op_q.imm;

    // Until the first op arrives the result must read as zero, not PC_wb=ILEN_B.
    always_comb begin
        res_c = '0;
        if (seen_q) begin
            res_c.cmp_res = cmp_raw & ~jump;
            res_c.taken   = res_c.cmp_res | jump;
            res_c.pc_jump = op_q.jalr ? {base_sum[XLEN-1:1], 1'b0} : (op_q.pc + op_q.imm);
            res_c.pc_wb   = op_q.pc + XLEN'(ILEN_B);
            res_c.mis     = (res_c.taken != op_q.pred_taken) ||
                            (res_c.taken && (res_c.pc_jump != op_q.pred_target));
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
        res_t r;
        if (k == 0) begin : g_head
            assign r = res_c;
        end else begin : g_dly
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r <= '0;
                end else if (valid_q[k-1] && !ifc.flush) begin
                    r <= g_stg[k-1].r;
                end
            end
        end
    end

    assign r_out          = g_stg[LATENCY-1].r;
    assign ifc.done       = valid_q[LATENCY-1];
    assign ifc.PC_jump    = r_out.pc_jump;
    assign ifc.PC_wb      = r_out.pc_wb;
    assign ifc.cmp_res    = r_out.cmp_res;
    assign ifc.taken      = r_out.taken;
    assign ifc.mispredict = valid_q[LATENCY-1] & r_out.mis;

    a_jal_jalr_exclusive: assert property (
        @(posedge clk) disable iff (!rst) ifc.EN |-> !(ifc.is_jal && ifc.JALR)
    ) else $error("fu_jump_pipe: is_jal and JALR issued together");

endmodule

// File: tb/tb_fu_jump_pipe.sv
// tb/tb_fu_jump_pipe.sv - directed self-checking bench for fu_jump_pipe at LATENCY 1, 2 and 4
module tb_fu_jump_pipe;
    import fu_jump_pkg::*;

    localparam int LATS [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush, is_jal, jalr, pt;
    logic [2:0]  ctrl;
    logic [31:0] rs1, rs2, imm, pc, ptgt;

    int errors = 0;
    int checks = 0;

    logic        done_a [3];
    logic        mis_a  [3];
    logic        cmp_a  [3];
    logic        tkn_a  [3];
    logic [31:0] pcj_a  [3];
    logic [31:0] pcwb_a [3];

    always #5 clk = ~clk;

    fu_jump_pipe_if #(.XLEN(32)) ifs [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ifs[g].EN          = en;
        assign ifs[g].flush       = flush;
        assign ifs[g].is_jal      = is_jal;
        assign ifs[g].JALR        = jalr;
        assign ifs[g].cmp_ctrl    = ctrl;
        assign ifs[g].rs1_data    = rs1;
        assign ifs[g].rs2_data    = rs2;
        assign ifs[g].imm         = imm;
        assign ifs[g].PC          = pc;
        assign ifs[g].pred_taken  = pt;
        assign ifs[g].pred_target = ptgt;
        assign done_a[g]          = ifs[g].done;
        assign mis_a[g]           = ifs[g].mispredict;
        assign cmp_a[g]           = ifs[g].cmp_res;
        assign tkn_a[g]           = ifs[g].taken;
        assign pcj_a[g]           = ifs[g].PC_jump;
        assign pcwb_a[g]          = ifs[g].PC_wb;

        fu_jump_pipe #(.XLEN(32), .LATENCY(LATS[g]), .ILEN_B(4)) u_dut (
            .clk (clk),
            .rst (rst_n),
            .ifc (ifs[g])
        );
    end

    task automatic drive(input logic j, input logic r, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic ptk, input logic [31:0] ptg);
        en = 1'b1; is_jal = j; jalr = r; ctrl = c;
        rs1 = a; rs2 = b; imm = im; pc = p; pt = ptk; ptgt = ptg;
    endtask

    // Issue one op and wait (bounded) for the LATENCY=2 instance to report done.
    task automatic run_one(input logic j, input logic r, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [31:0] p, input logic ptk, input logic [31:0] ptg,
                           output bit got, output int lat);
        @(negedge clk);
        drive(j, r, c, a, b, im, p, ptk, ptg);
        @(negedge clk);
        en  = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_a[1]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            checks++; if (done_a[j] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", j, done_a[j]); end
            checks++; if (pcj_a[j] !== 32'h0) begin errors++; $display("FAIL reset_pc_jump[%0d]: got %h want 0", j, pcj_a[j]); end
            checks++; if (pcwb_a[j] !== 32'h0) begin errors++; $display("FAIL reset_pc_wb[%0d]: got %h want 0", j, pcwb_a[j]); end
            checks++; if ({tkn_a[j], cmp_a[j], mis_a[j]} !== 3'b000) begin errors++; $display("FAIL reset_flags[%0d]: got %b want 000", j, {tkn_a[j], cmp_a[j], mis_a[j]}); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_beq;
        bit got; int lat;
        run_one(1'b0, 1'b0, EQ, 32'd5, 32'd5, 32'h10, 32'h100, 1'b0, 32'h0, got, lat);
        checks++; if (!got) begin errors++; $display("FAIL beq_done: got no done want done"); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL beq_latency: got %0d want 2", lat); end
        checks++; if (pcj_a[1] !== 32'h110) begin errors++; $display("FAIL beq_pc_jump: got %h want 00000110", pcj_a[1]); end
        checks++; if (pcwb_a[1] !== 32'h104) begin errors++; $display("FAIL beq_pc_wb: got %h want 00000104", pcwb_a[1]); end
        checks++; if ({cmp_a[1], tkn_a[1], mis_a[1]} !== 3'b111) begin errors++; $display("FAIL beq_flags: got %b want 111", {cmp_a[1], tkn_a[1], mis_a[1]}); end
        @(negedge clk);
        checks++; if ({done_a[1], mis_a[1]} !== 2'b00) begin errors++; $display("FAIL beq_pulse: got %b want 00", {done_a[1], mis_a[1]}); end
        checks++; if (pcj_a[1] !== 32'h110 || tkn_a[1] !== 1'b1) begin errors++; $display("FAIL beq_hold: got %h/%b want 00000110/1", pcj_a[1], tkn_a[1]); end
    endtask

    task automatic test_jumps;
        bit got; int lat;
        run_one(1'b0, 1'b1, CMP_NONE, 32'h203, 32'h0, 32'h4, 32'h40, 1'b1, 32'h206, got, lat);
        checks++; if (!got) begin errors++; $display("FAIL jalr_done: got no done want done"); end
        checks++; if (pcj_a[1] !== 32'h206) begin errors++; $display("FAIL jalr_pc_jump: got %h want 00000206", pcj_a[1]); end
        checks++; if (pcwb_a[1] !== 32'h44) begin errors++; $display("FAIL jalr_pc_wb: got %h want 00000044", pcwb_a[1]); end
        checks++; if ({cmp_a[1], tkn_a[1], mis_a[1]} !== 3'b010) begin errors++; $display("FAIL jalr_flags: got %b want 010", {cmp_a[1], tkn_a[1], mis_a[1]}); end
        run_one(1'b1, 1'b0, EQ, 32'd7, 32'd7, 32'h20, 32'h1000, 1'b1, 32'h1020, got, lat);
        checks++; if (pcj_a[1] !== 32'h1020 || !got) begin errors++; $display("FAIL jal_pc_jump: got %h want 00001020", pcj_a[1]); end
        checks++; if ({cmp_a[1], tkn_a[1], mis_a[1]} !== 3'b010) begin errors++; $display("FAIL jal_ignores_cmp: got %b want 010", {cmp_a[1], tkn_a[1], mis_a[1]}); end
        run_one(1'b1, 1'b0, EQ, 32'd7, 32'd7, 32'h20, 32'h1000, 1'b1, 32'h1024, got, lat);
        checks++; if (mis_a[1] !== 1'b1 || !got) begin errors++; $display("FAIL jal_target_mispredict: got %b want 1", mis_a[1]); end
    endtask

    task automatic test_signed_wrap;
        logic [2:0] cs [5] = '{LT, LTU, GEU, GE, 3'd7};
        logic       ex [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit got; int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(1'b0, 1'b0, cs[i], 32'hFFFF_FFFF, 32'h1, 32'h8, 32'hFFFF_FFFC, 1'b0, 32'h0, got, lat);
            checks++; if (!got) begin errors++; $display("FAIL cmp_done ctrl=%0d: got no done want done", cs[i]); end
            checks++; if ({cmp_a[1], tkn_a[1], mis_a[1]} !== {3{ex[i]}}) begin errors++; $display("FAIL cmp_result ctrl=%0d: got %b want %b", cs[i], {cmp_a[1], tkn_a[1], mis_a[1]}, {3{ex[i]}}); end
            checks++; if (pcj_a[1] !== 32'h4 || pcwb_a[1] !== 32'h0) begin errors++; $display("FAIL wrap ctrl=%0d: got %h/%h want 00000004/00000000", cs[i], pcj_a[1], pcwb_a[1]); end
        end
    endtask

    task automatic test_back_to_back;
        int cnt [3] = '{0, 0, 0};
        int k;
        logic [31:0] ep;
        en = 1'b0;
        repeat (6) @(negedge clk);
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (done_a[j]) begin
                    k  = cnt[j];
                    ep = 32'h1040 + 32'(20 * k);
                    checks++;
                    if (k >= 5 || t != k + LATS[j]) begin
                        errors++; $display("FAIL b2b_timing L=%0d: got done at %0d for op %0d want %0d", LATS[j], t, k, k + LATS[j]);
                    end else if (pcj_a[j] !== ep || tkn_a[j] !== (k % 2 == 0) || mis_a[j] !== (k % 2 == 0)) begin
                        errors++; $display("FAIL b2b_result L=%0d op %0d: got %h/%b/%b want %h/%b/%b", LATS[j], k, pcj_a[j], tkn_a[j], mis_a[j], ep, k % 2 == 0, k % 2 == 0);
                    end
                    cnt[j]++;
                end
            end
            if (t < 5) drive(1'b0, 1'b0, EQ, 32'(t), 32'((t % 2 == 1) ? t + 1 : t), 32'(32'h40 + 16 * t), 32'(32'h1000 + 4 * t), 1'b0, 32'h0);
            else en = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            checks++; if (cnt[j] != 5) begin errors++; $display("FAIL b2b_count L=%0d: got %0d want 5", LATS[j], cnt[j]); end
        end
    endtask

    task automatic test_flush;
        logic exp;
        en = 1'b0; flush = 1'b0;
        repeat (6) @(negedge clk);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                exp = (j == 0) ? (t == 1 || t == 2 || t == 3 || t == 5) :
                      (j == 1) ? (t == 2 || t == 3 || t == 6) : (t == 8);
                checks++; if (done_a[j] !== exp) begin errors++; $display("FAIL flush_done L=%0d t=%0d: got %b want %b", LATS[j], t, done_a[j], exp); end
            end
            if (t == 8) begin
                checks++; if (pcj_a[2] !== 32'h3030 || tkn_a[2] !== 1'b1 || mis_a[2] !== 1'b0) begin errors++; $display("FAIL flush_next_op: got %h/%b/%b want 00003030/1/0", pcj_a[2], tkn_a[2], mis_a[2]); end
            end
            flush = (t == 3);
            if (t < 4) drive(1'b1, 1'b0, CMP_NONE, 32'h0, 32'h0, 32'h100, 32'(32'h2000 + 4 * t), 1'b1, 32'h0);
            else if (t == 4) drive(1'b0, 1'b0, NE, 32'h1, 32'h2, 32'h30, 32'h3000, 1'b1, 32'h3030);
            else en = 1'b0;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit got; int lat;
        en = 1'b0;
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b0, CMP_NONE, 32'h0, 32'h0, 32'h10, 32'h500, 1'b0, 32'h0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (done_a[j] !== 1'b0 || pcj_a[j] !== 32'h0 || pcwb_a[j] !== 32'h0) begin errors++; $display("FAIL rst_mid_clear L=%0d: got %b/%h/%h want 0/0/0", LATS[j], done_a[j], pcj_a[j], pcwb_a[j]); end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++; if ({done_a[0], done_a[1], done_a[2]} !== 3'b000 || pcj_a[1] !== 32'h0 || tkn_a[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_after t=%0d: got %b/%h/%b want 000/0/0", t, {done_a[0], done_a[1], done_a[2]}, pcj_a[1], tkn_a[1]); end
        end
        run_one(1'b0, 1'b0, LTU, 32'h1, 32'h2, 32'h8, 32'h600, 1'b0, 32'h0, got, lat);
        checks++; if (!got || pcj_a[1] !== 32'h608 || mis_a[1] !== 1'b1) begin errors++; $display("FAIL rst_resume: got %b/%h/%b want 1/00000608/1", got, pcj_a[1], mis_a[1]); end
    endtask

    initial begin
        en = 1'b0; flush = 1'b0; is_jal = 1'b0; jalr = 1'b0; pt = 1'b0; ctrl = CMP_NONE;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0; ptgt = '0;
        rst_n = 1'b0;
        test_reset();
        test_beq();
        test_jumps();
        test_signed_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
